// File: rtl/reg_bus_pkg.sv
// Shared encodings for the register RS/RW/Din/Dout access bus.
// Op codes and FSM states used by the master, slaves and control unit.
package reg_bus_pkg;

    typedef enum logic [1:0] {
        OP_RD  = 2'b00,
        OP_WR  = 2'b01,
        OP_SET = 2'b10,
        OP_CLR = 2'b11
    } op_e;

    typedef enum logic [2:0] {
        IDLE,
        RD_ACC,
        RD_CAP,
        WR_ACC,
        RESP
    } state_e;

    localparam logic BUS_RD = 1'b0;
    localparam logic BUS_WR = 1'b1;

    function automatic int sel_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/reg_bus_master.sv
// Initiator for the register RS/RW/Din/Dout bus: read, write, optional RMW.
// Set/clear read-modify-write is compiled only with REG_BUS_MASTER_RMW_EN.
module reg_bus_master
    import reg_bus_pkg::*;
#(
    parameter int NUM_REGS = 4,
    parameter int DATA_W   = 8,
    localparam int SEL_W   = sel_width(NUM_REGS)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       cmd_valid,
    output logic                       cmd_ready,
    input  logic [1:0]                 cmd_op,
    input  logic [SEL_W-1:0]           cmd_sel,
    input  logic [DATA_W-1:0]          cmd_wdata,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic [DATA_W-1:0]          rsp_data,
    output logic                       rsp_err,
    output logic [NUM_REGS-1:0]        bus_rs,
    output logic                       bus_rw,
    output logic [DATA_W-1:0]          bus_din,
    input  logic [NUM_REGS*DATA_W-1:0] bus_dout
);

    state_e              state_q, state_d;
    logic [SEL_W-1:0]    sel_q, sel_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic                err_q, err_d;
    logic [DATA_W-1:0]   rd_data;
`ifdef REG_BUS_MASTER_RMW_EN
    op_e                 op_q, op_d;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            sel_q   <= '0;
            data_q  <= '0;
            err_q   <= 1'b0;
`ifdef REG_BUS_MASTER_RMW_EN
            op_q    <= OP_RD;
`endif
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            data_q  <= data_d;
            err_q   <= err_d;
`ifdef REG_BUS_MASTER_RMW_EN
            op_q    <= op_d;
`endif
        end
    end

    always_comb begin
        rd_data = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (sel_q == SEL_W'(i)) begin
                rd_data = bus_dout[i*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        data_d  = data_q;
        err_d   = err_q;
`ifdef REG_BUS_MASTER_RMW_EN
        op_d    = op_q;
`endif
        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    sel_d  = cmd_sel;
                    data_d = cmd_wdata;
                    err_d  = 1'b0;
`ifdef REG_BUS_MASTER_RMW_EN
                    op_d   = op_e'(cmd_op);
`endif
                    if (int'(cmd_sel) >= NUM_REGS) begin
                        err_d   = 1'b1;
                        data_d  = '0;
                        state_d = RESP;
                    end else begin
                        unique case (cmd_op)
                            OP_RD:   state_d = RD_ACC;
                            OP_WR:   state_d = WR_ACC;
`ifdef REG_BUS_MASTER_RMW_EN
                            default: state_d = RD_ACC;
`else
                            default: begin
                                err_d   = 1'b1;
                                data_d  = '0;
                                state_d = RESP;
                            end
`endif
                        endcase
                    end
                end
            end
            RD_ACC: state_d = RD_CAP;
            RD_CAP: begin
`ifdef REG_BUS_MASTER_RMW_EN
                unique case (op_q)
                    OP_SET: begin
                        data_d  = rd_data | data_q;
                        state_d = WR_ACC;
                    end
                    OP_CLR: begin
                        data_d  = rd_data & ~data_q;
                        state_d = WR_ACC;
                    end
                    default: begin
                        data_d  = rd_data;
                        state_d = RESP;
                    end
                endcase
`else
                data_d  = rd_data;
                state_d = RESP;
`endif
            end
            WR_ACC: state_d = RESP;
            RESP: begin
                if (rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        cmd_ready = (state_q == IDLE) && !rst;
        rsp_valid = 1'b0;
        rsp_data  = '0;
        rsp_err   = 1'b0;
        bus_rs    = '0;
        bus_rw    = BUS_RD;
        bus_din   = '0;
        case (state_q)
            RD_ACC, RD_CAP, WR_ACC: begin
                for (int i = 0; i < NUM_REGS; i++) begin
                    bus_rs[i] = (sel_q == SEL_W'(i));
                end
                if (state_q == WR_ACC) begin
                    bus_rw  = BUS_WR;
                    bus_din = data_q;
                end
            end
            RESP: begin
                rsp_valid = 1'b1;
                rsp_data  = data_q;
                rsp_err   = err_q;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_reg_bus_master.sv
// Directed bench for reg_bus_master (4-slave instance plus a 5-slave
// instance so an out-of-range select index is representable).
module tb_reg_bus_master;
    import reg_bus_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [1:0]  cmd_op = 2'b00;
    logic [2:0]  cmd_sel = 3'd0;
    logic [7:0]  cmd_wdata = 8'h00;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [7:0]  rsp_data;
    logic        rsp_err;
    logic [3:0]  bus_rs;
    logic        bus_rw;
    logic [7:0]  bus_din;
    logic [31:0] bus_dout = 32'h0;

    logic        cmd_valid5 = 1'b0;
    logic        cmd_ready5;
    logic        rsp_valid5;
    logic        rsp_ready5 = 1'b0;
    logic [7:0]  rsp_data5;
    logic        rsp_err5;
    logic [4:0]  bus_rs5;
    logic        bus_rw5;
    logic [7:0]  bus_din5;
    logic [39:0] bus_dout5;

    int vectors = 0;
    int miscompares = 0;

    assign bus_dout5 = {8'h00, bus_dout};

    always #5 clk = ~clk;

    reg_bus_master #(.NUM_REGS(4), .DATA_W(8)) u_dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_sel(cmd_sel[1:0]), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_err(rsp_err),
        .bus_rs(bus_rs), .bus_rw(bus_rw), .bus_din(bus_din),
        .bus_dout(bus_dout)
    );

    reg_bus_master #(.NUM_REGS(5), .DATA_W(8)) u_dut5 (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid5), .cmd_ready(cmd_ready5),
        .cmd_op(cmd_op), .cmd_sel(cmd_sel), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid5), .rsp_ready(rsp_ready5),
        .rsp_data(rsp_data5), .rsp_err(rsp_err5),
        .bus_rs(bus_rs5), .bus_rw(bus_rw5), .bus_din(bus_din5),
        .bus_dout(bus_dout5)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic chk_idle_bus(input string tag);
        chk({tag, ".rs"}, 32'(bus_rs), 32'h0);
        chk({tag, ".rw"}, 32'(bus_rw), 32'h0);
        chk({tag, ".din"}, 32'(bus_din), 32'h0);
    endtask

    task automatic issue(input logic [1:0] op, input logic [2:0] sel,
                         input logic [7:0] wd);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_sel   = sel;
        cmd_wdata = wd;
        tick();
        cmd_valid = 1'b0;
        cmd_op    = 2'b01;
        cmd_sel   = 3'd3;
        cmd_wdata = 8'h55;
    endtask

    initial begin
        // reset state
        tick();
        chk("rst.cmd_ready", 32'(cmd_ready), 32'h0);
        chk("rst.rsp_valid", 32'(rsp_valid), 32'h0);
        chk("rst.rsp_err", 32'(rsp_err), 32'h0);
        chk("rst.rsp_data", 32'(rsp_data), 32'h0);
        chk_idle_bus("rst");
        rst = 1'b0;
        #1;
        chk("post_rst.cmd_ready", 32'(cmd_ready), 32'h1);

        // write sel=1 data=FF
        issue(2'b01, 3'd1, 8'hFF);
        chk("wr.acc.rs", 32'(bus_rs), 32'h2);
        chk("wr.acc.rw", 32'(bus_rw), 32'h1);
        chk("wr.acc.din", 32'(bus_din), 32'hFF);
        chk("wr.acc.cmd_ready", 32'(cmd_ready), 32'h0);
        chk("wr.acc.rsp_valid", 32'(rsp_valid), 32'h0);
        tick();
        chk("wr.rsp.valid", 32'(rsp_valid), 32'h1);
        chk("wr.rsp.data", 32'(rsp_data), 32'hFF);
        chk("wr.rsp.err", 32'(rsp_err), 32'h0);
        chk_idle_bus("wr.rsp");
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        chk("wr.done.valid", 32'(rsp_valid), 32'h0);
        chk("wr.done.cmd_ready", 32'(cmd_ready), 32'h1);

        // read sel=1, slave1 holds FF, then stall the response
        bus_dout = 32'h0000_FF00;
        issue(2'b00, 3'd1, 8'h00);
        chk("rd.acc.rs", 32'(bus_rs), 32'h2);
        chk("rd.acc.rw", 32'(bus_rw), 32'h0);
        tick();
        chk("rd.cap.rs", 32'(bus_rs), 32'h2);
        chk("rd.cap.rw", 32'(bus_rw), 32'h0);
        chk("rd.cap.rsp_valid", 32'(rsp_valid), 32'h0);
        tick();
        chk("rd.rsp.valid", 32'(rsp_valid), 32'h1);
        chk("rd.rsp.data", 32'(rsp_data), 32'hFF);
        bus_dout = 32'h1234_0078;
        cmd_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("stall.valid", 32'(rsp_valid), 32'h1);
            chk("stall.data", 32'(rsp_data), 32'hFF);
            chk("stall.cmd_ready", 32'(cmd_ready), 32'h0);
            chk_idle_bus("stall");
        end
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        chk("stall.release.valid", 32'(rsp_valid), 32'h0);
        chk("stall.release.cmd_ready", 32'(cmd_ready), 32'h1);

        // write sel=3 checks the top select line
        issue(2'b01, 3'd3, 8'h5A);
        chk("wr3.rs", 32'(bus_rs), 32'h8);
        chk("wr3.din", 32'(bus_din), 32'h5A);
        tick();
        chk("wr3.rsp.data", 32'(rsp_data), 32'h5A);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;

        // out-of-range select on the 5-slave instance
        cmd_valid5 = 1'b1;
        cmd_op     = 2'b00;
        cmd_sel    = 3'd5;
        tick();
        cmd_valid5 = 1'b0;
        chk("sel5.valid", 32'(rsp_valid5), 32'h1);
        chk("sel5.err", 32'(rsp_err5), 32'h1);
        chk("sel5.data", 32'(rsp_data5), 32'h0);
        chk("sel5.rs", 32'(bus_rs5), 32'h0);
        chk("sel5.rw", 32'(bus_rw5), 32'h0);
        rsp_ready5 = 1'b1;
        tick();
        rsp_ready5 = 1'b0;
        chk("sel5.done", 32'(rsp_valid5), 32'h0);
        chk("sel5.cmd_ready", 32'(cmd_ready5), 32'h1);

        // reset during RD_CAP
        bus_dout = 32'h00A0_0000;
`ifdef REG_BUS_MASTER_RMW_EN
        issue(2'b10, 3'd2, 8'h0F);
`else
        issue(2'b00, 3'd2, 8'h0F);
`endif
        chk("rstmid.acc.rs", 32'(bus_rs), 32'h4);
        tick();
        chk("rstmid.cap.rs", 32'(bus_rs), 32'h4);
        chk("rstmid.cap.rw", 32'(bus_rw), 32'h0);
        rst = 1'b1;
        tick();
        chk("rstmid.cmd_ready", 32'(cmd_ready), 32'h0);
        chk("rstmid.rsp_valid", 32'(rsp_valid), 32'h0);
        chk("rstmid.rsp_data", 32'(rsp_data), 32'h0);
        chk("rstmid.rsp_err", 32'(rsp_err), 32'h0);
        chk_idle_bus("rstmid");
        rst = 1'b0;
        #1;
        chk("rstmid.after.cmd_ready", 32'(cmd_ready), 32'h1);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rstmid.after.rw", 32'(bus_rw), 32'h0);
            chk("rstmid.after.valid", 32'(rsp_valid), 32'h0);
        end

        // set mask 0F on slave2 holding A0
        issue(2'b10, 3'd2, 8'h0F);
`ifdef REG_BUS_MASTER_RMW_EN
        chk("set.acc.rs", 32'(bus_rs), 32'h4);
        tick();
        chk("set.cap.rw", 32'(bus_rw), 32'h0);
        tick();
        chk("set.wr.rs", 32'(bus_rs), 32'h4);
        chk("set.wr.rw", 32'(bus_rw), 32'h1);
        chk("set.wr.din", 32'(bus_din), 32'hAF);
        tick();
        chk("set.rsp.data", 32'(rsp_data), 32'hAF);
        chk("set.rsp.err", 32'(rsp_err), 32'h0);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        // clear mask 0F on slave0 holding FF
        bus_dout = 32'h0000_00FF;
        issue(2'b11, 3'd0, 8'h0F);
        tick();
        tick();
        chk("clr.wr.rs", 32'(bus_rs), 32'h1);
        chk("clr.wr.din", 32'(bus_din), 32'hF0);
        tick();
        chk("clr.rsp.data", 32'(rsp_data), 32'hF0);
`else
        chk("set.rsp.valid", 32'(rsp_valid), 32'h1);
        chk("set.rsp.err", 32'(rsp_err), 32'h1);
        chk("set.rsp.data", 32'(rsp_data), 32'h0);
        chk_idle_bus("set.rsp");
`endif
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        chk("final.cmd_ready", 32'(cmd_ready), 32'h1);
        chk("final.rsp_valid", 32'(rsp_valid), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
